// File: rtl/sfi_pkg.sv
// Shared constants and opcode classification for the SFI rewrite arbiter.
// The sandboxed opcodes are the store-class instructions that must carry the region tag.
package sfi_pkg;

  localparam int WORD_W  = 64;
  localparam int OPC_LSB = 26;
  localparam int OPC_W   = 6;
  localparam int TAG_W   = 8;

  typedef enum logic [OPC_W-1:0] {
    OP_SB  = 6'd40,
    OP_SH  = 6'd41,
    OP_SWL = 6'd42,
    OP_SW  = 6'd43,
    OP_SDL = 6'd44,
    OP_SDR = 6'd45,
    OP_SWR = 6'd46,
    OP_SC  = 6'd56,
    OP_SCD = 6'd60,
    OP_SD  = 6'd63
  } sbx_op_e;

  function automatic logic is_sandboxed(input logic [OPC_W-1:0] op);
    case (op)
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SDL,
      OP_SDR, OP_SWR, OP_SC, OP_SCD, OP_SD: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sfi_rewrite_arbiter_if.sv
// Requester-side and output-side handshake bundle of the SFI rewrite arbiter.
// The slave modport is the arbiter's view; master is the surrounding fabric's view.
interface sfi_rewrite_arbiter_if
  import sfi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*WORD_W-1:0] req_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [WORD_W-1:0]         out_data;
  logic [ID_W-1:0]           out_id;
  logic                      out_sandboxed;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_sandboxed
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, out_sandboxed
  );

endinterface

// File: rtl/sfi_rewrite.sv
// Combinational SFI rewrite: store-class words get the region tag in their top byte,
// everything else passes through untouched.
module sfi_rewrite
  import sfi_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic [WORD_W-1:0] word_o,
  output logic              sandboxed_o
);

  assign sandboxed_o = is_sandboxed(word_i[OPC_LSB +: OPC_W]);
  assign word_o      = sandboxed_o ? {tag_i, word_i[WORD_W-TAG_W-1:0]} : word_i;

endmodule

// File: rtl/sfi_rewrite_arbiter.sv
// Round-robin arbiter sharing one SFI rewrite path between NUM_REQ requesters,
// with a single-entry output buffer, the sandbox tag register and a rewrite counter.
module sfi_rewrite_arbiter
  import sfi_pkg::*;
#(
  parameter int               NUM_REQ   = 4,
  parameter int               ID_W      = $clog2(NUM_REQ),
  parameter logic [TAG_W-1:0] TAG_RESET = 8'hA2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               cfg_we_i,
  input  logic [TAG_W-1:0]   cfg_tag_i,
  output logic [TAG_W-1:0]   tag_o,
  output logic [31:0]        rewrite_count_o,
  sfi_rewrite_arbiter_if.slave bus
);

  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic              out_sb_q, out_sb_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [31:0]       count_q, count_d;

  logic              load;
  logic              xfer;
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W:0]     cand;
  logic [WORD_W-1:0] gnt_word;
  logic [WORD_W-1:0] rw_word;
  logic              rw_sb;

  assign load = en_i & (~out_valid_q | bus.out_ready);

  // Candidate index is kept one bit wider so the modulo wrap is a single subtract.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!gnt_found && bus.req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign xfer = load & gnt_found & ~rst_i;

  always_comb begin
    bus.req_ready = '0;
    if (xfer) begin
      bus.req_ready[gnt_idx] = 1'b1;
    end
  end

  assign gnt_word = bus.req_data[gnt_idx*WORD_W +: WORD_W];

  sfi_rewrite u_rewrite (
    .word_i      (gnt_word),
    .tag_i       (tag_q),
    .word_o      (rw_word),
    .sandboxed_o (rw_sb)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_sb_d    = out_sb_q;
    rr_ptr_d    = rr_ptr_q;
    tag_d       = tag_q;
    count_d     = count_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = rw_word;
      out_id_d    = gnt_idx;
      out_sb_d    = rw_sb;
      rr_ptr_d    = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      if (rw_sb && (count_q != 32'hFFFF_FFFF)) begin
        count_d = count_q + 32'd1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    // The word granted this cycle was already rewritten with the old tag above.
    if (cfg_we_i) begin
      tag_d = cfg_tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_sb_q    <= 1'b0;
      rr_ptr_q    <= '0;
      tag_q       <= TAG_RESET;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_sb_q    <= out_sb_d;
      rr_ptr_q    <= rr_ptr_d;
      tag_q       <= tag_d;
      count_q     <= count_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_id        = out_id_q;
  assign bus.out_sandboxed = out_sb_q;
  assign tag_o             = tag_q;
  assign rewrite_count_o   = count_q;

endmodule
